cast128_arbiter: RTL and testbench

CAST128_ARBITER -- requirements
Module: cast128_arbiter

---
 rtl/cast128_pkg.sv | 23 ++
 rtl/cast128_rr_arb.sv | 24 ++
 rtl/cast128_arbiter.sv | 127 ++++++++++++
 tb/tb_cast128_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cast128_pkg.sv
// cast128_pkg: shared types and sizes for the two-channel CAST-128 arbiter
package cast128_pkg;

    localparam int DW          = 64;
    localparam int KW          = 128;
    localparam int NCH         = 2;
    localparam int TMO_DEFAULT = 255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_KWAIT,
        S_DATA,
        S_DWAIT,
        S_DONE
    } state_t;

    // Winning channel index: a lone request wins, a tie goes to the channel not served last
    function automatic logic rr_pick(input logic [NCH-1:0] req, input logic last);
        return (req == 2'b11) ? ~last : req[1];
    endfunction

endpackage

// File: rtl/cast128_rr_arb.sv
// cast128_rr_arb: two-way round-robin grant with a last-served pointer
module cast128_rr_arb
    import cast128_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           take,
    output logic           win
);

    logic last;

    assign win = rr_pick(req, last);

    // Reset to "channel 1 served last" so channel 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (take)
            last <= win;
    end

endmodule

// File: rtl/cast128_arbiter.sv
// cast128_arbiter: shares one CAST-128 core between two request channels with key caching and a watchdog
module cast128_arbiter
    import cast128_pkg::*;
#(
    parameter int TMO = TMO_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          ENCDEC0,
    input  logic          ENCDEC1,
    input  logic [DW-1:0] DIN0,
    input  logic [DW-1:0] DIN1,
    input  logic [KW-1:0] KIN0,
    input  logic [KW-1:0] KIN1,
    input  logic          KNEW0,
    input  logic          KNEW1,
    output logic          ACK0,
    output logic          ACK1,
    output logic          DVLD0,
    output logic          DVLD1,
    output logic [DW-1:0] DOUT,
    output logic          ERR,
    output logic          C_EN,
    output logic          C_Krdy,
    output logic          C_Drdy,
    output logic          C_EncDec,
    output logic [KW-1:0] C_Kin,
    output logic [DW-1:0] C_Din,
    input  logic          C_BSY,
    input  logic          C_Kvld,
    input  logic          C_Dvld,
    input  logic [DW-1:0] C_Dout
);

    state_t        state, state_nx;
    logic [7:0]    wdog;
    logic          win, grant, need_key, waiting, expire;
    logic          gch, key_valid, key_owner;
    logic          encdec_r, ack0_r, ack1_r, err_r, drdy_r, en_r;
    logic [DW-1:0] din_r, dout_r;
    logic [KW-1:0] key_r;

    cast128_rr_arb u_rr (
        .clk  (CLK),
        .rst  (RST),
        .req  ({REQ1, REQ0}),
        .take (grant),
        .win  (win)
    );

    assign grant    = (state == S_IDLE) && (REQ0 || REQ1);
    assign need_key = !key_valid || (key_owner != win) || (win ? KNEW1 : KNEW0);
    assign waiting  = (state == S_KWAIT && !C_Kvld) || (state == S_DWAIT && !C_Dvld) ||
                      (state == S_DATA && C_BSY);
    assign expire   = waiting && (wdog == 8'(TMO - 1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = grant ? (need_key ? S_KEY : S_DATA) : S_IDLE;
            S_KEY:   state_nx = S_KWAIT;
            S_KWAIT: state_nx = C_Kvld ? S_DATA : (expire ? S_IDLE : S_KWAIT);
            S_DATA:  state_nx = !C_BSY ? S_DWAIT : (expire ? S_IDLE : S_DATA);
            S_DWAIT: state_nx = C_Dvld ? S_DONE : (expire ? S_IDLE : S_DWAIT);
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            wdog      <= 8'd0;
            gch       <= 1'b0;
            key_valid <= 1'b0;
            key_owner <= 1'b0;
            encdec_r  <= 1'b0;
            din_r     <= '0;
            key_r     <= '0;
            dout_r    <= '0;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            err_r     <= 1'b0;
            drdy_r    <= 1'b0;
            en_r      <= 1'b0;
        end else begin
            state  <= state_nx;
            en_r   <= 1'b1;
            wdog   <= (state_nx != state) ? 8'd0 : (waiting ? wdog + 8'd1 : wdog);
            ack0_r <= grant && !win;
            ack1_r <= grant && win;
            err_r  <= expire;
            // Core data strobe is registered so no core status input reaches an output combinationally
            drdy_r <= (state == S_DATA) && !C_BSY;
            if (grant) begin
                gch      <= win;
                encdec_r <= win ? ENCDEC1 : ENCDEC0;
                din_r    <= win ? DIN1 : DIN0;
                key_r    <= win ? KIN1 : KIN0;
            end
            if (state == S_KEY || expire)
                key_valid <= 1'b0;
            else if (state == S_KWAIT && C_Kvld) begin
                key_valid <= 1'b1;
                key_owner <= gch;
            end
            if (state == S_DWAIT && C_Dvld)
                dout_r <= C_Dout;
        end
    end

    assign ACK0     = ack0_r;
    assign ACK1     = ack1_r;
    assign DVLD0    = (state == S_DONE) && !gch;
    assign DVLD1    = (state == S_DONE) && gch;
    assign DOUT     = dout_r;
    assign ERR      = err_r;
    assign C_EN     = en_r;
    assign C_Krdy   = (state == S_KEY);
    assign C_Drdy   = drdy_r;
    assign C_EncDec = encdec_r;
    assign C_Kin    = key_r;
    assign C_Din    = din_r;

endmodule

// File: tb/tb_cast128_arbiter.sv
// tb_cast128_arbiter: directed-vector bench with a latency-modelled CAST-128 core stub
module tb_cast128_arbiter;

    localparam logic [127:0] K1 = 128'h0123456712345678234567893456789a;
    localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [63:0]  PT = 64'h0123456789abcdef;
    localparam logic [63:0]  CT = 64'h238b4fe5847e44b2;
    localparam logic [63:0]  D2 = 64'hfedcba9876543210;
    localparam logic [63:0]  R2 = 64'h76543210fedcba98;
    localparam int KLAT = 3;
    localparam int DLAT = 4;

    logic         CLK = 1'b0, RST = 1'b1;
    logic         REQ0 = 1'b0, REQ1 = 1'b0, ENCDEC0 = 1'b0, ENCDEC1 = 1'b0;
    logic         KNEW0 = 1'b0, KNEW1 = 1'b0;
    logic [63:0]  DIN0 = '0, DIN1 = '0;
    logic [127:0] KIN0 = '0, KIN1 = '0;
    logic         ACK0, ACK1, DVLD0, DVLD1, ERR, C_EN, C_Krdy, C_Drdy, C_EncDec;
    logic [63:0]  DOUT, C_Din;
    logic [127:0] C_Kin;
    logic         C_BSY, C_Kvld = 1'b0, C_Dvld = 1'b0;
    logic [63:0]  C_Dout = '0;
    logic         bsy = 1'b0, hang = 1'b0;

    int checks = 0, failures = 0;
    int cyc = 0, krdy_cnt = 0, both_cnt = 0, drdy_cnt = 0;
    int drdy_cyc = 0, cdvld_cyc = 0, err_cyc = 0;

    always #5 CLK = ~CLK;
    assign C_BSY = bsy;

    cast128_arbiter #(.TMO(8)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .ENCDEC0(ENCDEC0), .ENCDEC1(ENCDEC1),
        .DIN0(DIN0), .DIN1(DIN1), .KIN0(KIN0), .KIN1(KIN1),
        .KNEW0(KNEW0), .KNEW1(KNEW1),
        .ACK0(ACK0), .ACK1(ACK1), .DVLD0(DVLD0), .DVLD1(DVLD1),
        .DOUT(DOUT), .ERR(ERR),
        .C_EN(C_EN), .C_Krdy(C_Krdy), .C_Drdy(C_Drdy), .C_EncDec(C_EncDec),
        .C_Kin(C_Kin), .C_Din(C_Din),
        .C_BSY(C_BSY), .C_Kvld(C_Kvld), .C_Dvld(C_Dvld), .C_Dout(C_Dout)
    );

    // Core stub: knows the reference vector pair, otherwise a key-dependent XOR
    function automatic logic [63:0] core_model(input logic [127:0] k, input logic [63:0] d, input logic e);
        if (k == K1 && !e && d == PT) return CT;
        if (k == K1 && e && d == CT) return PT;
        return d ^ k[63:0] ^ k[127:64];
    endfunction

    int           kcnt = 0, dcnt = 0;
    logic [127:0] sk = '0;
    logic [63:0]  sd = '0;
    logic         se = 1'b0;

    always @(posedge CLK) begin
        C_Kvld <= 1'b0;
        C_Dvld <= 1'b0;
        if (C_Krdy) begin
            sk   <= C_Kin;
            kcnt <= KLAT;
        end else if (kcnt > 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) C_Kvld <= 1'b1;
        end
        if (C_Drdy) begin
            sd   <= C_Din;
            se   <= C_EncDec;
            dcnt <= DLAT;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && !hang) begin
                C_Dvld <= 1'b1;
                C_Dout <= core_model(sk, sd, se);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (C_Krdy) krdy_cnt++;
        if (C_Krdy && C_Drdy) both_cnt++;
        if (C_Drdy) begin
            drdy_cnt++;
            drdy_cyc = cyc;
        end
        if (C_Dvld) cdvld_cyc = cyc;
        if (ERR) err_cyc = cyc;
    endtask

    task automatic issue(input logic ch, input logic [127:0] k, input logic [63:0] d,
                         input logic e, input logic kn, output int lat);
        if (ch) begin
            REQ1 = 1'b1; KIN1 = k; DIN1 = d; ENCDEC1 = e; KNEW1 = kn;
        end else begin
            REQ0 = 1'b1; KIN0 = k; DIN0 = d; ENCDEC0 = e; KNEW0 = kn;
        end
        lat = 0;
        for (int i = 0; i < 20 && lat == 0; i++) begin
            tick();
            if (ch ? ACK1 : ACK0) lat = i + 1;
        end
        if (ch) REQ1 = 1'b0;
        else REQ0 = 1'b0;
    endtask

    task automatic wait_done(input logic ch, output logic dv, output logic er);
        dv = 1'b0;
        er = 1'b0;
        for (int i = 0; i < 40 && !dv && !er; i++) begin
            tick();
            dv = ch ? DVLD1 : DVLD0;
            er = ERR;
        end
    endtask

    initial begin
        int   lat, k0, a0, a1, d0, d1;
        logic dv, er;
        logic [63:0] o0, o1;

        repeat (3) tick();
        chk("reset_pulses", 64'({ACK0, ACK1, DVLD0, DVLD1, ERR, C_Krdy, C_Drdy, C_EN}), 64'd0);
        chk("reset_dout", DOUT, 64'd0);
        RST = 1'b0;
        tick();
        chk("c_en_after_reset", 64'(C_EN), 64'd1);

        // Cold encrypt on ch0: key load then reference ciphertext
        k0 = krdy_cnt;
        issue(1'b0, K1, PT, 1'b0, 1'b1, lat);
        chk("t1_ack_lat", 64'(lat), 64'd1);
        wait_done(1'b0, dv, er);
        chk("t1_dvld", 64'(dv), 64'd1);
        chk("t1_krdy", 64'(krdy_cnt - k0), 64'd1);
        chk("t1_dout", DOUT, CT);

        // Same key, same channel: cached key, decrypt back
        k0 = krdy_cnt;
        issue(1'b0, K1, CT, 1'b1, 1'b0, lat);
        wait_done(1'b0, dv, er);
        chk("t2_dvld", 64'(dv), 64'd1);
        chk("t2_krdy", 64'(krdy_cnt - k0), 64'd0);
        chk("t2_dout", DOUT, PT);
        chk("t2_dvld_lag", 64'(cyc - cdvld_cyc), 64'd1);

        // Simultaneous requests after ch0 was served: ch1 first, each reloads key
        k0 = krdy_cnt;
        a0 = 0; a1 = 0; d0 = 0; d1 = 0; o0 = '0; o1 = '0;
        KIN0 = K1; DIN0 = PT; ENCDEC0 = 1'b0; KNEW0 = 1'b0;
        KIN1 = K2; DIN1 = D2; ENCDEC1 = 1'b0; KNEW1 = 1'b0;
        REQ0 = 1'b1; REQ1 = 1'b1;
        for (int i = 0; i < 80 && d0 == 0; i++) begin
            tick();
            if (ACK0) begin a0 = cyc; REQ0 = 1'b0; end
            if (ACK1) begin a1 = cyc; REQ1 = 1'b0; end
            if (DVLD1) begin d1 = cyc; o1 = DOUT; end
            if (DVLD0) begin d0 = cyc; o0 = DOUT; end
        end
        chk("t3_ack1_first", 64'(a1 != 0 && a1 < a0), 64'd1);
        chk("t3_ack0_after_done", 64'(a0 - d1), 64'd2);
        chk("t3_dout1", o1, R2);
        chk("t3_dout0", o0, CT);
        chk("t3_krdy", 64'(krdy_cnt - k0), 64'd2);

        // Core never answers: watchdog fires 8 cycles into DWAIT
        hang = 1'b1;
        issue(1'b0, K1, PT, 1'b0, 1'b0, lat);
        wait_done(1'b0, dv, er);
        chk("t4_err", 64'(er), 64'd1);
        chk("t4_no_dvld", 64'(dv), 64'd0);
        chk("t4_err_lag", 64'(err_cyc - drdy_cyc), 64'd8);
        tick();
        chk("t4_err_pulse", 64'(ERR), 64'd0);
        chk("t4_dout_held", DOUT, CT);
        hang = 1'b0;
        repeat (6) tick();

        // After a timeout the cached key is gone
        k0 = krdy_cnt;
        issue(1'b0, K1, CT, 1'b1, 1'b0, lat);
        wait_done(1'b0, dv, er);
        chk("t5_krdy", 64'(krdy_cnt - k0), 64'd1);
        chk("t5_dout", DOUT, PT);

        // Reset in KWAIT; late core key-valid must be ignored
        issue(1'b1, K2, D2, 1'b0, 1'b1, lat);
        chk("t6_key_state", 64'(C_Krdy), 64'd1);
        tick();
        RST = 1'b1;
        tick();
        chk("t6_reset_pulses", 64'({ACK0, ACK1, DVLD0, DVLD1, ERR, C_Krdy, C_Drdy, C_EN}), 64'd0);
        chk("t6_reset_dout", DOUT, 64'd0);
        RST = 1'b0;
        k0 = drdy_cnt;
        repeat (6) tick();
        chk("t6_idle_no_drdy", 64'(drdy_cnt - k0), 64'd0);
        k0 = krdy_cnt;
        issue(1'b1, K2, D2, 1'b0, 1'b0, lat);
        wait_done(1'b1, dv, er);
        chk("t6_krdy", 64'(krdy_cnt - k0), 64'd1);
        chk("t6_dout", DOUT, R2);

        // BSY high for the first 5 DATA cycles; strobe follows the first idle sample
        k0 = krdy_cnt;
        bsy = 1'b1;
        issue(1'b1, K2, D2, 1'b0, 1'b0, lat);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            chk("t7_drdy_held", 64'(C_Drdy), 64'd0);
        end
        bsy = 1'b0;
        tick();
        chk("t7_drdy", 64'(C_Drdy), 64'd1);
        wait_done(1'b1, dv, er);
        chk("t7_dvld", 64'(dv), 64'd1);
        chk("t7_krdy", 64'(krdy_cnt - k0), 64'd0);
        chk("t7_dout", DOUT, R2);

        // KNEW forces reload even when the cached key belongs to this channel
        k0 = krdy_cnt;
        issue(1'b1, K1, PT, 1'b0, 1'b1, lat);
        wait_done(1'b1, dv, er);
        chk("t8_krdy", 64'(krdy_cnt - k0), 64'd1);
        chk("t8_dout", DOUT, CT);

        chk("krdy_drdy_overlap", 64'(both_cnt), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
